pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the RV32I 5-stage core (IF/ID/EX/MEM/WB). It generates the per-stage STALL and FLUSH controls consumed by each stage latch. It resolves load-use hazards, taken branches and bus waits, and provides a debug halt/resume mode. A stage latch with FLUSH=1 loads zeros (VALID=0) at the next edge. A latch with STALL=1 holds its value. FLUSH has priority over STALL inside every latch.

Parameters:
INIT_FLUSH_CYCLES, 2, cycles of global flush after reset release (1..15)
PERF_W, 32, width of performance counters (only with PIPE_CTRL_PERF_EN)

Ports:
CLK  in  1  core clock
RST  in  1  reset, asynchronous, active-low
D_VALID  in  1  ID-stage latch holds a valid instruction
D_REG_S1  in  5  ID source register 1
D_REG_S2  in  5  ID source register 2
D_USE_S1  in  1  ID instruction reads rs1
D_USE_S2  in  1  ID instruction reads rs2
E_VALID  in  1  EX latch valid
E_IS_LOAD  in  1  EX instruction is a load
E_REG_D  in  5  EX destination register
E_BR_TAKEN  in  1  EX resolved a taken branch/jump (qualified by E_VALID internally)
E_BR_TARGET  in  32  redirect target
M_VALID  in  1  MEM latch valid
W_VALID  in  1  WB latch valid
I_BUSY  in  1  instruction bus not ready this cycle
D_BUSY  in  1  data bus not ready this cycle
HALT_REQ  in  1  debug halt request (level)
RESUME_REQ  in  1  debug resume (pulse)
STALL_IF/STALL_ID/STALL_EX/STALL_MEM/STALL_WB  out  1 each  stage hold
FLUSH_ID/FLUSH_EX/FLUSH_MEM/FLUSH_WB  out  1 each  stage clear
PC_SET  out  1  redirect fetch PC this cycle
PC_SET_ADDR  out  32  redirect address (= E_BR_TARGET)
HALTED  out  1  core is in HALTED state

Behaviour:
- FSM states: INIT, RUN, DRAIN, HALTED. Async reset -> INIT, init counter = INIT_FLUSH_CYCLES.
- INIT: FLUSH_ID/EX/MEM/WB=1 and STALL_IF=1. The counter decrements each cycle; at 1 -> RUN. No other events are honoured.
- RUN: HALT_REQ=1 -> DRAIN. Otherwise RUN.
- DRAIN: STALL_IF=1 and FLUSH_ID=1, so no new instructions enter. When E_VALID|M_VALID|W_VALID==0 and D_BUSY==0 -> HALTED.
- HALTED: all STALL_*=1, HALTED=1. RESUME_REQ -> RUN, regardless of HALT_REQ in that cycle. RESUME_REQ is ignored in the other states.
- Stall/flush terms in RUN/DRAIN are combinational, zero latency, and applied in priority order:
  1. D_BUSY: STALL_IF/ID/EX/MEM=1, FLUSH_WB=1. No redirect; the branch stays held in EX and is taken after the wait ends.
  2. Branch (E_VALID&E_BR_TAKEN): PC_SET=1, FLUSH_ID=1, FLUSH_EX=1. The load-use term is suppressed. I_BUSY does not block PC_SET; the fetch unit latches the redirect.
  3. Load-use: E_VALID&E_IS_LOAD&E_REG_D!=0&D_VALID and (D_USE_S1&S1==RD or D_USE_S2&S2==RD). Effect: STALL_IF=1, STALL_ID=1, FLUSH_EX=1. Exactly one bubble per hazard.
  4. I_BUSY (no higher term): STALL_IF=1, FLUSH_ID=1.
  Terms 2-4 may combine, with FLUSH taking precedence per stage.
- PC_SET is asserted in DRAIN as well, so the resume PC is correct. PC_SET=0 in INIT and HALTED.
- Outputs in reset: all STALL_*=0, PC_SET=0, HALTED=0, FLUSH_*=1 (INIT).
- Reset asserted mid-wait or mid-drain returns the FSM to INIT immediately.

Optional Feature:
PIPE_CTRL_PERF_EN: adds outputs PERF_STALL_CNT, PERF_FLUSH_CNT and PERF_HALT_CNT, each [PERF_W-1:0].
- PERF_STALL_CNT counts RUN cycles with STALL_IF=1.
- PERF_FLUSH_CNT counts PC_SET cycles.
- PERF_HALT_CNT counts HALTED cycles.
- Counters saturate at all-ones and are cleared by reset.
- Without the macro: no counters and no extra ports.

Decomposition:
- Shared cpu_pkg header holds the FSM state encodings (INIT/RUN/DRAIN/HALTED, 2 bits) and REG_ZERO=5'd0.
- One natural sub-module: hazard_det, a combinational load-use comparator producing a single HAZ flag.

Test Plan:
- Reset released at t0, INIT_FLUSH_CYCLES=2 -> FLUSH_*=1 for 2 cycles, then RUN with all outputs 0.
- lw x5 in EX, add x6,x5,x1 in ID (D_USE_S1=1) -> exactly 1 cycle with STALL_IF=STALL_ID=FLUSH_EX=1. Repeat with E_REG_D=0 -> no stall.
- E_BR_TAKEN=1, target 0x0000_0100, with a load-use hazard in the same cycle -> PC_SET=1, PC_SET_ADDR=0x100, FLUSH_ID=FLUSH_EX=1, STALL_ID=0.
- D_BUSY high 3 cycles while a branch sits in EX -> 3 cycles with STALL_IF..MEM=1, FLUSH_WB=1, PC_SET=0. PC_SET=1 on the 4th cycle.
- HALT_REQ with E/M/W valid -> DRAIN until all valid=0, then HALTED=1. RESUME_REQ pulse -> RUN next cycle.
- RST pulsed low while in DRAIN -> outputs return to reset values asynchronously, INIT on release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: sequencer state encodings and the hardwired zero register.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } pipeState_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source operand only conflicts when it is actually read and names the producing register.
    function automatic logic srcMatch(input logic use_i, input logic [4:0] src_i,
                                      input logic [4:0] dst_i);
        return use_i && (src_i == dst_i);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard comparator: flags an ID instruction that needs the result of a load still in EX.
module hazard_det
    import cpu_pkg::*;
(
    input  logic       dValid_i,
    input  logic [4:0] dRegS1_i,
    input  logic [4:0] dRegS2_i,
    input  logic       dUseS1_i,
    input  logic       dUseS2_i,
    input  logic       eValid_i,
    input  logic       eIsLoad_i,
    input  logic [4:0] eRegD_i,
    output logic       haz_o
);

    logic loadInEx;
    logic srcHit;

    // Writes to x0 are discarded, so a load targeting x0 can never create a dependency.
    assign loadInEx = eValid_i && eIsLoad_i && (eRegD_i != REG_ZERO);
    assign srcHit   = srcMatch(dUseS1_i, dRegS1_i, eRegD_i) ||
                      srcMatch(dUseS2_i, dRegS2_i, eRegD_i);
    assign haz_o    = loadInEx && dValid_i && srcHit;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage STALL/FLUSH, branch redirect and debug halt/resume for the 5-stage core.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int INIT_FLUSH_CYCLES = 2
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D_VALID,
    input  logic [4:0]  D_REG_S1,
    input  logic [4:0]  D_REG_S2,
    input  logic        D_USE_S1,
    input  logic        D_USE_S2,
    input  logic        E_VALID,
    input  logic        E_IS_LOAD,
    input  logic [4:0]  E_REG_D,
    input  logic        E_BR_TAKEN,
    input  logic [31:0] E_BR_TARGET,
    input  logic        M_VALID,
    input  logic        W_VALID,
    input  logic        I_BUSY,
    input  logic        D_BUSY,
    input  logic        HALT_REQ,
    input  logic        RESUME_REQ,
    output logic        STALL_IF,
    output logic        STALL_ID,
    output logic        STALL_EX,
    output logic        STALL_MEM,
    output logic        STALL_WB,
    output logic        FLUSH_ID,
    output logic        FLUSH_EX,
    output logic        FLUSH_MEM,
    output logic        FLUSH_WB,
    output logic        PC_SET,
    output logic [31:0] PC_SET_ADDR,
    output logic        HALTED
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] PERF_STALL_CNT,
    output logic [PERF_W-1:0] PERF_FLUSH_CNT,
    output logic [PERF_W-1:0] PERF_HALT_CNT
`endif
);

    localparam logic [3:0] INIT_CNT = 4'(INIT_FLUSH_CYCLES);

    pipeState_t state_q, state_d;
    logic [3:0] initCnt_q, initCnt_d;
    logic       halted_q, halted_d;

    logic haz;
    logic brTaken;
    logic pipeEmpty;

    hazard_det u_hazard_det (
        .dValid_i (D_VALID),
        .dRegS1_i (D_REG_S1),
        .dRegS2_i (D_REG_S2),
        .dUseS1_i (D_USE_S1),
        .dUseS2_i (D_USE_S2),
        .eValid_i (E_VALID),
        .eIsLoad_i(E_IS_LOAD),
        .eRegD_i  (E_REG_D),
        .haz_o    (haz)
    );

    assign brTaken   = E_VALID && E_BR_TAKEN;
    assign pipeEmpty = !(E_VALID || M_VALID || W_VALID);

    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (initCnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                end else begin
                    initCnt_d = initCnt_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (HALT_REQ) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pipeEmpty && !D_BUSY) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (RESUME_REQ) state_d = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_INIT;
            initCnt_q <= INIT_CNT;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
            halted_q  <= halted_d;
        end
    end

    assign HALTED      = halted_q;
    assign PC_SET_ADDR = E_BR_TARGET;

    // Stall/flush terms are zero-latency; the stage latches resolve FLUSH over STALL themselves.
    always_comb begin
        STALL_IF  = 1'b0;
        STALL_ID  = 1'b0;
        STALL_EX  = 1'b0;
        STALL_MEM = 1'b0;
        STALL_WB  = 1'b0;
        FLUSH_ID  = 1'b0;
        FLUSH_EX  = 1'b0;
        FLUSH_MEM = 1'b0;
        FLUSH_WB  = 1'b0;
        PC_SET    = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                // Fetch is only held once reset is released; while in reset every stall stays low.
                STALL_IF  = RST;
                FLUSH_ID  = 1'b1;
                FLUSH_EX  = 1'b1;
                FLUSH_MEM = 1'b1;
                FLUSH_WB  = 1'b1;
            end
            ST_HALTED: begin
                STALL_IF  = 1'b1;
                STALL_ID  = 1'b1;
                STALL_EX  = 1'b1;
                STALL_MEM = 1'b1;
                STALL_WB  = 1'b1;
            end
            default: begin
                if (D_BUSY) begin
                    STALL_IF  = 1'b1;
                    STALL_ID  = 1'b1;
                    STALL_EX  = 1'b1;
                    STALL_MEM = 1'b1;
                    FLUSH_WB  = 1'b1;
                end else if (brTaken) begin
                    PC_SET   = 1'b1;
                    FLUSH_ID = 1'b1;
                    FLUSH_EX = 1'b1;
                end else if (haz) begin
                    STALL_IF = 1'b1;
                    STALL_ID = 1'b1;
                    FLUSH_EX = 1'b1;
                end else if (I_BUSY) begin
                    STALL_IF = 1'b1;
                    FLUSH_ID = 1'b1;
                end
                if (state_q == ST_DRAIN) begin
                    STALL_IF = 1'b1;
                    FLUSH_ID = 1'b1;
                end
            end
        endcase
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perfStall_q, perfFlush_q, perfHalt_q;

    // Counters stick at all-ones rather than wrapping so long runs never read as small values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perfStall_q <= '0;
            perfFlush_q <= '0;
            perfHalt_q  <= '0;
        end else begin
            if ((state_q == ST_RUN) && STALL_IF && !(&perfStall_q))
                perfStall_q <= perfStall_q + PERF_W'(1);
            if (PC_SET && !(&perfFlush_q))
                perfFlush_q <= perfFlush_q + PERF_W'(1);
            if ((state_q == ST_HALTED) && !(&perfHalt_q))
                perfHalt_q <= perfHalt_q + PERF_W'(1);
        end
    end

    assign PERF_STALL_CNT = perfStall_q;
    assign PERF_FLUSH_CNT = perfFlush_q;
    assign PERF_HALT_CNT  = perfHalt_q;
`endif

endmodule
